// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and NZCV bit positions for alu_seq.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_ORR   = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_LSL   = 4'b1001;
  localparam logic [3:0] OP_LSR   = 4'b1010;
  localparam logic [3:0] OP_UDIV  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative radix-2 datapath: shift-add multiply, plus restoring unsigned
// divide when ALU_SEQ_UDIV_EN is defined. One step per clock, WIDTH steps.
module alu_seq_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
`ifdef ALU_SEQ_UDIV_EN
  input  logic             div_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt_q;
  logic             run_q;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;

`ifdef ALU_SEQ_UDIV_EN
  // Divide: acc holds the partial remainder, a shifts the dividend out and the quotient in.
  logic             div_q;
  logic [WIDTH:0]   rem_ext;
  logic [WIDTH:0]   rem_sub;
  assign rem_ext = {acc_q, a_q[WIDTH-1]};
  assign rem_sub = rem_ext - {1'b0, b_q};
`endif

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
`ifdef ALU_SEQ_UDIV_EN
    if (div_q) begin
      if (!rem_sub[WIDTH]) begin
        acc_d = rem_sub[WIDTH-1:0];
        a_d   = {a_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = rem_ext[WIDTH-1:0];
        a_d   = {a_q[WIDTH-2:0], 1'b0};
      end
    end else
`endif
    begin
      acc_d = acc_q + (b_q[0] ? a_q : '0);
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
    end
  end

  assign done_o = run_q && (cnt_q == CW'(WIDTH - 1));
`ifdef ALU_SEQ_UDIV_EN
  assign result_o = div_q ? a_d : acc_d;
`else
  assign result_o = acc_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
`ifdef ALU_SEQ_UDIV_EN
      div_q <= 1'b0;
`endif
    end else if (start_i) begin
      cnt_q <= '0;
      run_q <= 1'b1;
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= '0;
`ifdef ALU_SEQ_UDIV_EN
      div_q <= div_i;
`endif
    end else if (run_q) begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      if (done_o) begin
        run_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered results and NZCV flags; MUL (and UDIV when
// ALU_SEQ_UDIV_EN is defined) run on the iterative datapath in alu_seq_iter.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_nzcv,
  output logic             out_illegal
);

  localparam int SW = $clog2(WIDTH);

  state_t           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_result_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [3:0]       out_nzcv_q;
  logic             out_illegal_q;

  logic             accept;
  logic             is_multi;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v, sc_ill;
  logic             iter_done;
  logic [WIDTH-1:0] iter_res;
  logic             mc_v;

  function automatic logic [3:0] nzcv_of(input logic [WIDTH-1:0] r, input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[NZCV_N] = r[WIDTH-1];
    f[NZCV_Z] = (r == '0);
    f[NZCV_C] = c;
    f[NZCV_V] = v;
    return f;
  endfunction

  assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept   = in_valid && in_ready;
`ifdef ALU_SEQ_UDIV_EN
  assign is_multi = (in_op == OP_MUL) || (in_op == OP_UDIV);
`else
  assign is_multi = (in_op == OP_MUL);
`endif

  assign sum  = {1'b0, in_a} + {1'b0, in_b};
  assign diff = {1'b0, in_a} - {1'b0, in_b};

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_ill = 1'b0;
    case (in_op)
      OP_AND:   sc_res = in_a & in_b;
      OP_ORR:   sc_res = in_a | in_b;
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff[WIDTH-1:0];
        sc_c   = ~diff[WIDTH];
        sc_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_PASSB: sc_res = in_b;
      OP_NOR:   sc_res = ~(in_a | in_b);
      OP_LSL:   sc_res = in_a << in_b[SW-1:0];
      OP_LSR:   sc_res = in_a >> in_b[SW-1:0];
      default:  sc_ill = 1'b1;
    endcase
  end

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (accept && is_multi),
`ifdef ALU_SEQ_UDIV_EN
    .div_i    (in_op == OP_UDIV),
`endif
    .a_i      (in_a),
    .b_i      (in_b),
    .done_o   (iter_done),
    .result_o (iter_res)
  );

`ifdef ALU_SEQ_UDIV_EN
  // Divide-by-zero is reported on V; the restoring divider already yields all-ones.
  logic dbz_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  dbz_q <= 1'b0;
    else if (accept && is_multi) dbz_q <= (in_op == OP_UDIV) && (in_b == '0);
  end
  assign mc_v = dbz_q;
`else
  assign mc_v = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_tag_q     <= '0;
      out_nzcv_q    <= 4'b0100;
      out_illegal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            out_tag_q <= in_tag;
            if (is_multi) begin
              state_q     <= BUSY;
              out_valid_q <= 1'b0;
            end else begin
              state_q       <= DONE;
              out_valid_q   <= 1'b1;
              out_result_q  <= sc_res;
              out_nzcv_q    <= nzcv_of(sc_res, sc_c, sc_v);
              out_illegal_q <= sc_ill;
            end
          end else if (state_q == DONE && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        BUSY: begin
          if (iter_done) begin
            state_q       <= DONE;
            out_valid_q   <= 1'b1;
            out_result_q  <= iter_res;
            out_nzcv_q    <= nzcv_of(iter_res, 1'b0, mc_v);
            out_illegal_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_tag     = out_tag_q;
  assign out_nzcv    = out_nzcv_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vectors, handshake/stall cases,
// mid-operation reset and randomized ops against a behavioural model.
module tb_alu_seq;

  localparam int W     = 64;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_op = '0;
  logic [W-1:0]     in_a = '0;
  logic [W-1:0]     in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     out_result;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_nzcv;
  logic             out_illegal;

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0] obs_res;
  logic [3:0]   obs_nzcv;
  logic         obs_ill;

  alu_seq #(.WIDTH(W), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_nzcv    (out_nzcv),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the opcode meanings, latency in cycles after accept.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [3:0] f, output logic ill,
                       output int lat);
    logic c, v;
    logic signed [W-1:0] sa, sb, rs;
    c = 1'b0; v = 1'b0; ill = 1'b0; lat = 1; r = '0;
    sa = a; sb = b;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        r = a + b; rs = r;
        c = (r < a);
        v = (sa >= 0 && sb >= 0 && rs < 0) || (sa < 0 && sb < 0 && rs >= 0);
      end
      4'b0110: begin
        r = a - b; rs = r;
        c = (a >= b);
        v = (sa >= 0 && sb < 0 && rs < 0) || (sa < 0 && sb >= 0 && rs >= 0);
      end
      4'b0111: r = b;
      4'b1100: r = ~(a | b);
      4'b1001: r = a << (b % W);
      4'b1010: r = a >> (b % W);
      4'b1000: begin r = a * b; lat = W + 1; end
`ifdef ALU_SEQ_UDIV_EN
      4'b1011: begin
        r = (b == 0) ? {W{1'b1}} : a / b;
        v = (b == 0);
        lat = W + 1;
      end
`endif
      default: begin r = '0; ill = 1'b1; end
    endcase
    f = {r[W-1], r == 0, c, v};
  endtask

  // Called at a negedge; returns at the negedge where the result is visible.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TAG_W-1:0] tag);
    logic [W-1:0] er;
    logic [3:0]   ef;
    logic         eill;
    int           lat, cyc, low;
    bit           seen;
    model(op, a, b, er, ef, eill, lat);
    in_op = op; in_a = a; in_b = b; in_tag = tag;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("in_ready_pre", W'(in_ready), W'(1'b1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0; low = 0; seen = 1'b0;
    while (cyc < 200 && !seen) begin
      @(negedge clk);
      cyc++;
      if (out_valid) seen = 1'b1;
      else if (!in_ready) low++;
    end
    chk("latency", W'(cyc), W'(lat));
    chk("ready_low_cycles", W'(low), W'(lat - 1));
    chk("result", out_result, er);
    chk("nzcv", W'(out_nzcv), W'(ef));
    chk("illegal", W'(out_illegal), W'(eill));
    chk("tag", W'(out_tag), W'(tag));
    obs_res = out_result; obs_nzcv = out_nzcv; obs_ill = out_illegal;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [3:0]   rop;
    logic [W-1:0] er;
    logic [3:0]   ef;
    logic         eill;
    int           lat, vcnt;
    logic [W-1:0] vals [3];
    logic [TAG_W-1:0] tags [3];
    logic [3:0]   ops [3];

    #12;
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_in_ready", W'(in_ready), W'(1'b1));
    chk("rst_result", out_result, '0);
    chk("rst_tag", W'(out_tag), '0);
    chk("rst_nzcv", W'(out_nzcv), W'(4'b0100));
    chk("rst_illegal", W'(out_illegal), '0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run_op(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd3);
    chk("add_ovf_res", obs_res, 64'h8000_0000_0000_0000);
    chk("add_ovf_nzcv", W'(obs_nzcv), W'(4'b1001));
    run_op(4'b0110, 64'd5, 64'd5, 5'd4);
    chk("sub_eq_res", obs_res, 64'd0);
    chk("sub_eq_nzcv", W'(obs_nzcv), W'(4'b0110));
    run_op(4'b0110, 64'd3, 64'd5, 5'd5);
    chk("sub_lt_res", obs_res, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_lt_nzcv", W'(obs_nzcv), W'(4'b1000));
    run_op(4'b1000, 64'd12345, 64'd1000, 5'd17);
    chk("mul_res", obs_res, 64'd12345000);
    run_op(4'b1111, 64'd9, 64'd9, 5'd1);
    chk("ill_res", obs_res, 64'd0);
    chk("ill_flag", W'(obs_ill), W'(1'b1));
    run_op(4'b1001, 64'd1, 64'd67, 5'd2);
    chk("lsl_mask", obs_res, 64'd8);
`ifdef ALU_SEQ_UDIV_EN
    run_op(4'b1011, 64'd100, 64'd7, 5'd6);
    chk("udiv_res", obs_res, 64'd14);
    run_op(4'b1011, 64'd100, 64'd0, 5'd7);
    chk("udiv_dbz_res", obs_res, {W{1'b1}});
    chk("udiv_dbz_v", W'(obs_nzcv[0]), W'(1'b1));
    chk("udiv_dbz_ill", W'(obs_ill), '0);
`else
    run_op(4'b1011, 64'd100, 64'd7, 5'd6);
    chk("udiv_off_ill", W'(obs_ill), W'(1'b1));
    chk("udiv_off_res", obs_res, 64'd0);
`endif

    // Back-to-back AND/ORR/NOR, then stall the consumer.
    @(negedge clk);
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      vals[i] = {$urandom, $urandom};
      tags[i] = TAG_W'(i + 9);
    end
    in_a = 64'hF0F0_1234_5678_9ABC;
    in_valid = 1'b1; out_ready = 1'b1;
    in_op = ops[0]; in_b = vals[0]; in_tag = tags[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (i < 2) begin
        in_op = ops[i+1]; in_b = vals[i+1]; in_tag = tags[i+1];
      end else begin
        in_valid = 1'b0; out_ready = 1'b0;
      end
      @(negedge clk);
      model(ops[i], 64'hF0F0_1234_5678_9ABC, vals[i], er, ef, eill, lat);
      chk("b2b_valid", W'(out_valid), W'(1'b1));
      chk("b2b_result", out_result, er);
      chk("b2b_tag", W'(out_tag), W'(tags[i]));
    end
    model(4'b1100, 64'hF0F0_1234_5678_9ABC, vals[2], er, ef, eill, lat);
    in_valid = 1'b1; in_op = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", W'(out_valid), W'(1'b1));
      chk("stall_result", out_result, er);
      chk("stall_nzcv", W'(out_nzcv), W'(ef));
      chk("stall_in_ready", W'(in_ready), '0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("drain_valid", W'(out_valid), '0);

    // Reset in the middle of a MUL.
    in_op = 4'b1000; in_a = 64'd777; in_b = 64'd999; in_tag = 5'd21; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", W'(out_valid), '0);
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < W + 5; i++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    chk("midrst_no_stale", W'(vcnt), '0);
    chk("midrst_in_ready", W'(in_ready), W'(1'b1));
    chk("midrst_result", out_result, '0);

    // Randomized ops, biased toward corner operands.
    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: rb = '0;
        2: ra = {W{1'b1}};
        3: rb = W'($urandom_range(0, 200));
        default: ;
      endcase
      run_op(rop, ra, rb, TAG_W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
